// File: rtl/apb_rw_scheduler_if.sv
// apb_rw_scheduler_if: read/write request-response channels plus the 10-slave APB bus.
// The master modport is the scheduler's view; the slave modport is the surrounding system.
interface apb_rw_scheduler_if #(
   parameter int DATASIZE = 32,
   parameter int ADDRSIZE = 32
);
   logic                  rd_req_valid, rd_req_ready;
   logic [ADDRSIZE-1:0]   rd_req_addr;
   logic [2:0]            rd_req_prot;
   logic                  rd_rsp_valid, rd_rsp_ready;
   logic [DATASIZE-1:0]   rd_rsp_data;
   logic                  rd_rsp_err;
   logic                  wr_req_valid, wr_req_ready;
   logic [ADDRSIZE-1:0]   wr_req_addr;
   logic [DATASIZE-1:0]   wr_req_data;
   logic [DATASIZE/8-1:0] wr_req_strb;
   logic [2:0]            wr_req_prot;
   logic                  wr_rsp_valid, wr_rsp_ready;
   logic                  wr_rsp_err;
   logic [9:0]            PSEL;
   logic                  PENABLE, PWRITE;
   logic [ADDRSIZE-1:0]   PADDR;
   logic [DATASIZE-1:0]   PWDATA;
   logic [2:0]            PPROT;
   logic [DATASIZE/8-1:0] PSTRB;
   logic [9:0]            pready, pslverr;
   logic [DATASIZE-1:0]   prdata0, prdata1, prdata2, prdata3, prdata4;
   logic [DATASIZE-1:0]   prdata5, prdata6, prdata7, prdata8, prdata9;
   modport master (
      input  rd_req_valid, rd_req_addr, rd_req_prot, rd_rsp_ready,
             wr_req_valid, wr_req_addr, wr_req_data, wr_req_strb, wr_req_prot, wr_rsp_ready,
             pready, pslverr, prdata0, prdata1, prdata2, prdata3, prdata4,
             prdata5, prdata6, prdata7, prdata8, prdata9,
      output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err,
             wr_req_ready, wr_rsp_valid, wr_rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PSTRB
   );
   modport slave (
      output rd_req_valid, rd_req_addr, rd_req_prot, rd_rsp_ready,
             wr_req_valid, wr_req_addr, wr_req_data, wr_req_strb, wr_req_prot, wr_rsp_ready,
             pready, pslverr, prdata0, prdata1, prdata2, prdata3, prdata4,
             prdata5, prdata6, prdata7, prdata8, prdata9,
      input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err,
             wr_req_ready, wr_rsp_valid, wr_rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PSTRB
   );
endinterface

// File: rtl/apb_rw_scheduler.sv
// apb_rw_scheduler: round-robin read/write arbiter driving one APB transfer at a time,
// slave decoded from addr[15:12] (10-15 = decode error), with an ACCESS wait timeout.
module apb_rw_scheduler #(
   parameter int DATASIZE = 32,
   parameter int ADDRSIZE = 32,
   parameter int TIMEOUT  = 255
) (
   input logic clk,
   input logic reset,
   apb_rw_scheduler_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int SW = DATASIZE / 8;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                last_wr_q, last_wr_d;
   logic [3:0]          slot_q, slot_d;
   logic [9:0]          psel_q, psel_d;
   logic                penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDRSIZE-1:0] paddr_q, paddr_d;
   logic [DATASIZE-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
   logic [2:0]          pprot_q, pprot_d;
   logic [SW-1:0]       pstrb_q, pstrb_d;
   logic                rd_v_q, rd_v_d, wr_v_q, wr_v_d, err_q, err_d;
   logic                grant_wr, rd_acc, wr_acc, sel_ready, expired;
   logic [ADDRSIZE-1:0] req_addr;
   logic [DATASIZE-1:0] prdata [10];
   assign prdata = '{bus.prdata0, bus.prdata1, bus.prdata2, bus.prdata3, bus.prdata4,
                     bus.prdata5, bus.prdata6, bus.prdata7, bus.prdata8, bus.prdata9};
   // a write only wins a tie when the previous grant went to a read
   assign grant_wr = bus.wr_req_valid && (!bus.rd_req_valid || !last_wr_q);
   assign rd_acc   = state_q == IDLE && bus.rd_req_valid && !grant_wr;
   assign wr_acc   = state_q == IDLE && grant_wr;
   assign req_addr = wr_acc ? bus.wr_req_addr : bus.rd_req_addr;
   assign sel_ready = bus.pready[slot_q];
   assign expired   = cnt_q == CW'(TIMEOUT - 1);
   assign bus.rd_req_ready = rd_acc;
   assign bus.wr_req_ready = wr_acc;
   assign bus.PSEL    = psel_q;
   assign bus.PENABLE = penable_q;
   assign bus.PWRITE  = pwrite_q;
   assign bus.PADDR   = paddr_q;
   assign bus.PWDATA  = pwdata_q;
   assign bus.PPROT   = pprot_q;
   assign bus.PSTRB   = pstrb_q;
   assign bus.rd_rsp_valid = rd_v_q;
   assign bus.wr_rsp_valid = wr_v_q;
   assign bus.rd_rsp_data  = rdata_q;
   assign bus.rd_rsp_err   = err_q;
   assign bus.wr_rsp_err   = err_q;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_wr_d = last_wr_q;
      slot_d    = slot_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pprot_d   = pprot_q;
      pstrb_d   = pstrb_q;
      rd_v_d    = rd_v_q;
      wr_v_d    = wr_v_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         IDLE: if (rd_acc || wr_acc) begin
            slot_d   = req_addr[15:12];
            pwrite_d = wr_acc;
            paddr_d  = req_addr;
            pwdata_d = wr_acc ? bus.wr_req_data : '0;
            pstrb_d  = wr_acc ? bus.wr_req_strb : '0;
            pprot_d  = wr_acc ? bus.wr_req_prot : bus.rd_req_prot;
            cnt_d    = '0;
            if (slot_d < 4'd10) begin
               state_d = SETUP;
               psel_d  = 10'(1) << slot_d;
            end else begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
               rd_v_d  = !wr_acc;
               wr_v_d  = wr_acc;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: if (sel_ready || expired) begin
            state_d   = RESP;
            psel_d    = '0;
            penable_d = 1'b0;
            err_d     = sel_ready ? bus.pslverr[slot_q] : 1'b1;
            rdata_d   = (sel_ready && !pwrite_q) ? prdata[slot_q] : '0;
            rd_v_d    = !pwrite_q;
            wr_v_d    = pwrite_q;
         end else cnt_d = cnt_q + 1'b1;
         RESP: if ((rd_v_q && bus.rd_rsp_ready) || (wr_v_q && bus.wr_rsp_ready)) begin
            state_d   = IDLE;
            rd_v_d    = 1'b0;
            wr_v_d    = 1'b0;
            last_wr_d = pwrite_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_wr_q <= 1'b1;
         slot_q    <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pprot_q   <= '0;
         pstrb_q   <= '0;
         rd_v_q    <= 1'b0;
         wr_v_q    <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_wr_q <= last_wr_d;
         slot_q    <= slot_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pprot_q   <= pprot_d;
         pstrb_q   <= pstrb_d;
         rd_v_q    <= rd_v_d;
         wr_v_q    <= wr_v_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
endmodule

// File: tb/tb_apb_rw_scheduler.sv
// tb_apb_rw_scheduler: directed and randomized transactions checked against a transaction-level model
// (decode, wait/timeout latency, error and data outcome, round-robin order).
module tb_apb_rw_scheduler;
   localparam int DW = 32, AW = 32, TMO = 8;
   logic          clk = 1'b0, reset;
   int            cyc = 0, tests = 0, fails = 0, acc_cnt = 0, wait_cfg = 0, n, prev;
   logic [9:0]    exp_sel = '0;
   bit            err_cfg = 1'b0, m_last_wr = 1'b1, r_tie, r_w;
   logic [DW-1:0] slv_data [10];
   logic [AW-1:0] r_a;
   apb_rw_scheduler_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();
   apb_rw_scheduler #(.DATASIZE(DW), .ADDRSIZE(AW), .TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;
   end
   // slave model: only the expected slave answers; the others report the opposite error
   assign bus.pready  = (bus.PENABLE && acc_cnt >= wait_cfg) ? exp_sel : '0;
   assign bus.pslverr = err_cfg ? exp_sel : ~exp_sel;
   assign bus.prdata0 = slv_data[0];
   assign bus.prdata1 = slv_data[1];
   assign bus.prdata2 = slv_data[2];
   assign bus.prdata3 = slv_data[3];
   assign bus.prdata4 = slv_data[4];
   assign bus.prdata5 = slv_data[5];
   assign bus.prdata6 = slv_data[6];
   assign bus.prdata7 = slv_data[7];
   assign bus.prdata8 = slv_data[8];
   assign bus.prdata9 = slv_data[9];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic txn(input bit w_en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] s, input logic [2:0] p, input int ws, input bit pe, input bit tie);
      int slot, exp_lat, lat;
      bit dec_err, tmo, exp_e;
      logic [DW-1:0] exp_d;
      slot    = int'(a[15:12]);
      dec_err = slot > 9;
      tmo     = !dec_err && ws >= TMO;
      exp_lat = dec_err ? 1 : tmo ? 2 + TMO : 3 + ws;
      wait_cfg = ws;
      err_cfg  = pe;
      exp_sel  = dec_err ? 10'd0 : 10'(1) << slot;
      foreach (slv_data[k]) slv_data[k] = $urandom;
      exp_d = (!w_en && !dec_err && !tmo) ? slv_data[slot] : '0;
      exp_e = dec_err || tmo || pe;
      bus.wr_req_valid = w_en || tie;
      bus.rd_req_valid = !w_en || tie;
      bus.rd_req_addr  = w_en ? $urandom : a;
      bus.rd_req_prot  = w_en ? 3'($urandom) : p;
      bus.wr_req_addr  = w_en ? a : $urandom;
      bus.wr_req_data  = w_en ? d : $urandom;
      bus.wr_req_strb  = w_en ? s : 4'($urandom);
      bus.wr_req_prot  = w_en ? p : 3'($urandom);
      #1;
      chk("grant_rd", bus.rd_req_ready, !w_en);
      chk("grant_wr", bus.wr_req_ready, w_en);
      @(posedge clk);
      @(negedge clk);
      chk("busy_ready", {bus.rd_req_ready, bus.wr_req_ready}, 0);
      bus.rd_req_valid = 1'b0;
      bus.wr_req_valid = 1'b0;
      lat = 1;
      while (!(bus.rd_rsp_valid || bus.wr_rsp_valid) && lat < exp_lat + 20) begin
         if (!dec_err && lat == 1) begin
            chk("setup_ctl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PPROT, bus.PSTRB},
                {exp_sel, 1'b0, w_en, p, w_en ? s : 4'h0});
            chk("setup_addr", bus.PADDR, a);
            chk("setup_wdata", bus.PWDATA, w_en ? d : '0);
         end
         if (!dec_err && lat == 2) chk("access_ctl", {bus.PENABLE, bus.PSEL}, {1'b1, exp_sel});
         @(negedge clk);
         lat++;
      end
      chk("rsp_lat", lat, exp_lat);
      chk("rsp_chan", {bus.rd_rsp_valid, bus.wr_rsp_valid}, {!w_en, w_en});
      chk("rsp_err", w_en ? bus.wr_rsp_err : bus.rd_rsp_err, exp_e);
      if (!w_en) chk("rsp_data", bus.rd_rsp_data, exp_d);
      chk("rsp_bus_idle", {bus.PSEL, bus.PENABLE}, 0);
      @(negedge clk);
      chk("rsp_hold", {bus.rd_rsp_valid, bus.wr_rsp_valid, w_en ? bus.wr_rsp_err : bus.rd_rsp_err},
          {!w_en, w_en, exp_e});
      if (!w_en) chk("rsp_hold_data", bus.rd_rsp_data, exp_d);
      bus.rd_rsp_ready = !w_en;
      bus.wr_rsp_ready = w_en;
      @(negedge clk);
      chk("rsp_done", {bus.rd_rsp_valid, bus.wr_rsp_valid}, 0);
      bus.rd_rsp_ready = 1'b0;
      bus.wr_rsp_ready = 1'b0;
      m_last_wr = w_en;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      foreach (slv_data[k]) slv_data[k] = '0;
      bus.rd_req_valid = 0; bus.rd_req_addr = '0; bus.rd_req_prot = '0; bus.rd_rsp_ready = 0;
      bus.wr_req_valid = 0; bus.wr_req_addr = '0; bus.wr_req_data = '0; bus.wr_req_strb = '0;
      bus.wr_req_prot = '0; bus.wr_rsp_ready = 0;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PPROT, bus.PSTRB}, 0);
      chk("rst_addr_data", {bus.PADDR, bus.PWDATA}, 0);
      chk("rst_rsp", {bus.rd_rsp_valid, bus.wr_rsp_valid, bus.rd_rsp_err, bus.wr_rsp_err, bus.rd_rsp_data}, 0);
      reset = 1'b0;
      // simultaneous requests out of reset, responses always accepted: R,W,R,W every 4 cycles
      bus.rd_req_addr = 32'h0000_1000;
      bus.wr_req_addr = 32'h0000_1010;
      exp_sel = 10'h002; wait_cfg = 0; err_cfg = 1'b0;
      bus.rd_req_valid = 1; bus.wr_req_valid = 1; bus.rd_rsp_ready = 1; bus.wr_rsp_ready = 1;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n = 0;
         while (!(bus.rd_req_ready || bus.wr_req_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk("tie_order", {bus.rd_req_ready, bus.wr_req_ready}, (i % 2) ? 2'b01 : 2'b10);
         if (i > 0) chk("tie_gap", cyc - prev, 4);
         prev = cyc;
         @(negedge clk);
      end
      bus.rd_req_valid = 0; bus.wr_req_valid = 0;
      repeat (4) @(negedge clk);
      bus.rd_rsp_ready = 0; bus.wr_rsp_ready = 0;
      m_last_wr = 1'b1;
      // directed cases
      txn(1'b0, 32'h0000_3004, '0, 4'h0, 3'd2, 0, 1'b0, 1'b0);
      txn(1'b1, 32'h0000_9010, 32'h1234_5678, 4'hF, 3'd1, 4, 1'b1, 1'b0);
      txn(1'b0, 32'h0000_B000, '0, 4'h0, 3'd0, 0, 1'b0, 1'b0);
      txn(1'b1, 32'h0000_2000, 32'hCAFE_0001, 4'h3, 3'd0, 50, 1'b0, 1'b0);
      txn(1'b0, 32'h0000_7008, '0, 4'h0, 3'd5, TMO - 1, 1'b0, 1'b0);
      txn(1'b1, 32'h0000_7008, 32'hA5A5_5A5A, 4'h9, 3'd7, TMO, 1'b0, 1'b0);
      // reset in the middle of an ACCESS phase
      wait_cfg = 50; exp_sel = 10'h020; err_cfg = 1'b0;
      bus.rd_req_addr = 32'h0000_5000;
      bus.rd_req_valid = 1;
      @(posedge clk);
      @(negedge clk);
      bus.rd_req_valid = 0;
      @(negedge clk);
      chk("pre_rst_access", {bus.PSEL, bus.PENABLE}, {10'h020, 1'b1});
      #2 reset = 1'b1;
      #1 chk("rst_async", {bus.PSEL, bus.PENABLE, bus.rd_rsp_valid, bus.wr_rsp_valid}, 0);
      @(negedge clk);
      reset = 1'b0;
      m_last_wr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_quiet", {bus.PSEL, bus.PENABLE, bus.rd_rsp_valid, bus.wr_rsp_valid}, 0);
      end
      txn(1'b1, 32'h0000_4044, 32'h0BAD_F00D, 4'h5, 3'd3, 1, 1'b0, 1'b0);
      // randomized traffic, including ties resolved by the round-robin flag
      for (int i = 0; i < 40; i++) begin
         r_tie = $urandom_range(0, 2) == 0;
         r_w   = r_tie ? !m_last_wr : 1'($urandom_range(0, 1));
         r_a   = $urandom;
         txn(r_w, r_a, $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 10),
             1'($urandom_range(0, 1)), r_tie);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
